// File: rtl/cache_axi_master_if.sv
`default_nettype none
// ============================================================================
// cache_axi_master_if : AXI4 read/write channel bundle seen by cache_axi_master.
// Revision: 1.0
// ============================================================================
interface cache_axi_master_if #(
  parameter int AXI_ID_BITS   = 4,
  parameter int AXI_ADDR_BITS = 32,
  parameter int AXI_DATA_BITS = 32,
  parameter int AXI_LEN_BITS  = 4
);
  logic [AXI_ID_BITS-1:0]     ARID_M;
  logic [AXI_ADDR_BITS-1:0]   ARADDR_M;
  logic [AXI_LEN_BITS-1:0]    ARLEN_M;
  logic [2:0]                 ARSIZE_M;
  logic [1:0]                 ARBURST_M;
  logic                       ARVALID_M;
  logic                       ARREADY_M;
  logic [AXI_ID_BITS-1:0]     RID_M;
  logic [AXI_DATA_BITS-1:0]   RDATA_M;
  logic [1:0]                 RRESP_M;
  logic                       RLAST_M;
  logic                       RVALID_M;
  logic                       RREADY_M;
  logic [AXI_ID_BITS-1:0]     AWID_M;
  logic [AXI_ADDR_BITS-1:0]   AWADDR_M;
  logic [AXI_LEN_BITS-1:0]    AWLEN_M;
  logic [2:0]                 AWSIZE_M;
  logic [1:0]                 AWBURST_M;
  logic                       AWVALID_M;
  logic                       AWREADY_M;
  logic [AXI_DATA_BITS-1:0]   WDATA_M;
  logic [AXI_DATA_BITS/8-1:0] WSTRB_M;
  logic                       WLAST_M;
  logic                       WVALID_M;
  logic                       WREADY_M;
  logic [AXI_ID_BITS-1:0]     BID_M;
  logic [1:0]                 BRESP_M;
  logic                       BVALID_M;
  logic                       BREADY_M;

  modport master (
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    input  ARREADY_M,
    input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    output RREADY_M,
    output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    input  AWREADY_M,
    output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
    input  WREADY_M,
    input  BID_M, BRESP_M, BVALID_M,
    output BREADY_M
  );

  modport slave (
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    output ARREADY_M,
    output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    input  RREADY_M,
    input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    output AWREADY_M,
    input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
    output WREADY_M,
    output BID_M, BRESP_M, BVALID_M,
    input  BREADY_M
  );
endinterface
`default_nettype wire

// File: rtl/cache_axi_master.sv
`default_nettype none
// ============================================================================
// cache_axi_master : turns one cache-line refill/write-back into one AXI4 INCR
// burst. Optional macro CACHE_AXI_WORD_FWD_EN adds per-beat forwarding outputs.
// Revision: 1.0
// ============================================================================
module cache_axi_master #(
  parameter logic [3:0] MASTER_ID  = 4'd1,
  parameter int         LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [31:0]                   req_addr,
  input  logic [32*LINE_WORDS-1:0]      req_wdata,
  output logic                          resp_valid,
  output logic                          resp_err,
  output logic [32*LINE_WORDS-1:0]      resp_rdata,
`ifdef CACHE_AXI_WORD_FWD_EN
  output logic                          fwd_valid,
  output logic [$clog2(LINE_WORDS)-1:0] fwd_idx,
  output logic [31:0]                   fwd_data,
`endif
  cache_axi_master_if.master            axi
);
  localparam int IDX_BITS  = $clog2(LINE_WORDS);
  localparam int BEAT_BITS = IDX_BITS + 1;
  localparam int OFF_BITS  = IDX_BITS + 2;
  localparam int LINE_BITS = 32 * LINE_WORDS;
  localparam int LEN_BITS  = 4;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_WORDS - 1);
  localparam logic [BEAT_BITS-1:0] BEAT_SAT  = BEAT_BITS'(LINE_WORDS);

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_t;

  state_t               state, state_next;
  logic [BEAT_BITS-1:0] beat, beat_next;
  logic                 err, err_next;
  logic [LINE_BITS-1:0] line, line_next;
  logic [31:0]          addr;
  logic [IDX_BITS-1:0]  beat_idx, beat_next_idx;
  logic                 accept, ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign req_ready     = (state == IDLE);
  assign accept        = req_valid & req_ready;
  assign ar_hs         = axi.ARVALID_M & axi.ARREADY_M;
  assign r_hs          = axi.RREADY_M & axi.RVALID_M;
  assign aw_hs         = axi.AWVALID_M & axi.AWREADY_M;
  assign w_hs          = axi.WVALID_M & axi.WREADY_M;
  assign b_hs          = axi.BREADY_M & axi.BVALID_M;
  assign beat_idx      = beat[IDX_BITS-1:0];
  assign beat_next_idx = beat_next[IDX_BITS-1:0];

  assign axi.ARID_M    = MASTER_ID;
  assign axi.ARADDR_M  = addr;
  assign axi.ARLEN_M   = LEN_BITS'(LINE_WORDS - 1);
  assign axi.ARSIZE_M  = 3'b010;
  assign axi.ARBURST_M = 2'b01;
  assign axi.AWID_M    = MASTER_ID;
  assign axi.AWADDR_M  = addr;
  assign axi.AWLEN_M   = LEN_BITS'(LINE_WORDS - 1);
  assign axi.AWSIZE_M  = 3'b010;
  assign axi.AWBURST_M = 2'b01;
  assign axi.WSTRB_M   = 4'hF;

  always_comb begin
    state_next = state;
    beat_next  = beat;
    err_next   = err;
    line_next  = line;
    case (state)
      IDLE: if (accept) begin
        state_next = req_write ? AW : AR;
        line_next  = req_wdata;
        beat_next  = '0;
      end
      AR: if (ar_hs) state_next = R;
      R: if (r_hs) begin
        // Beats past the end of the line are drained but never stored.
        if (beat != BEAT_SAT) begin
          line_next[32*beat_idx +: 32] = axi.RDATA_M;
          beat_next = beat + 1'b1;
        end
        if (axi.RRESP_M != 2'b00 || axi.RID_M != MASTER_ID) err_next = 1'b1;
        if (axi.RLAST_M && beat != LAST_BEAT)               err_next = 1'b1;
        if (!axi.RLAST_M && beat >= LAST_BEAT)              err_next = 1'b1;
        if (axi.RLAST_M) state_next = DONE;
      end
      AW: if (aw_hs) state_next = W;
      W: if (w_hs) begin
        beat_next = beat + 1'b1;
        if (beat == LAST_BEAT) state_next = B;
      end
      B: if (b_hs) begin
        if (axi.BRESP_M != 2'b00 || axi.BID_M != MASTER_ID) err_next = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        beat_next  = '0;
        err_next   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs are loaded from next-state so they are true flops, aligned with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat          <= '0;
      err           <= 1'b0;
      line          <= '0;
      addr          <= '0;
      axi.ARVALID_M <= 1'b0;
      axi.RREADY_M  <= 1'b0;
      axi.AWVALID_M <= 1'b0;
      axi.WVALID_M  <= 1'b0;
      axi.WDATA_M   <= '0;
      axi.WLAST_M   <= 1'b0;
      axi.BREADY_M  <= 1'b0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= '0;
    end else begin
      state         <= state_next;
      beat          <= beat_next;
      err           <= err_next;
      line          <= line_next;
      if (accept) addr <= {req_addr[31:OFF_BITS], OFF_BITS'(0)};
      axi.ARVALID_M <= (state_next == AR);
      axi.RREADY_M  <= (state_next == R);
      axi.AWVALID_M <= (state_next == AW);
      axi.WVALID_M  <= (state_next == W);
      axi.WDATA_M   <= line_next[32*beat_next_idx +: 32];
      axi.WLAST_M   <= (state_next == W) && (beat_next == LAST_BEAT);
      axi.BREADY_M  <= (state_next == B);
      resp_valid    <= (state_next == DONE);
      resp_err      <= (state_next == DONE) && err_next;
      if (state == R && state_next == DONE) resp_rdata <= line_next;
    end
  end

`ifdef CACHE_AXI_WORD_FWD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid <= 1'b0;
      fwd_idx   <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= (state == R) && r_hs;
      fwd_idx   <= beat_idx;
      fwd_data  <= axi.RDATA_M;
    end
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_cache_axi_master.sv
`default_nettype none
// ============================================================================
// tb_cache_axi_master : scoreboard bench with a cycle-level AXI slave model.
// Revision: 1.0
// ============================================================================
module tb_cache_axi_master;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            req_valid, req_ready, req_write;
  logic [31:0]     req_addr;
  logic [32*LW-1:0] req_wdata;
  logic            resp_valid, resp_err;
  logic [32*LW-1:0] resp_rdata;
`ifdef CACHE_AXI_WORD_FWD_EN
  logic            fwd_valid;
  logic [1:0]      fwd_idx;
  logic [31:0]     fwd_data;
`endif

  cache_axi_master_if axi ();

  cache_axi_master #(.MASTER_ID(4'd1), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
`ifdef CACHE_AXI_WORD_FWD_EN
    .fwd_valid(fwd_valid), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
`endif
    .axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              chk_data;
    logic            err;
    logic [32*LW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [32*LW-1:0] held_line = '0;
  bit   held_known = 1'b1;
  logic [31:0] rwords [LW];

  int   obs_nresp, obs_resp_t, obs_last_t, obs_nw, obs_w_early, obs_w_unstable;
  logic obs_err, obs_ready_in_done;
  logic [32*LW-1:0] obs_rdata;
  logic [31:0] obs_addr;
  logic [3:0]  obs_len, obs_id;
  logic [2:0]  obs_size;
  logic [1:0]  obs_burst;
  logic [5:0]  obs_rst_vec;
  logic [31:0] obs_wdata [LW];
  logic [LW-1:0] obs_wlast;

  task automatic slave_idle();
    axi.ARREADY_M = 0; axi.RVALID_M = 0; axi.RDATA_M = 0; axi.RRESP_M = 0;
    axi.RLAST_M = 0; axi.RID_M = 0; axi.AWREADY_M = 0; axi.WREADY_M = 0;
    axi.BVALID_M = 0; axi.BRESP_M = 0; axi.BID_M = 0;
  endtask

  task automatic note_resp(input int t);
    obs_nresp++;
    if (obs_resp_t < 0) obs_resp_t = t;
    obs_err = resp_err;
    obs_rdata = resp_rdata;
    obs_ready_in_done = req_ready;
  endtask

  // Refill with a zero-wait AR slave; gap = idle cycles between R beats.
  task automatic do_refill(input logic [31:0] addr, input int gap, input int err_beat,
                           input int last_beat, input int rst_beat);
    int  beat = 0, gapc = 0, arcnt = 0, rst_t = 0;
    bit  ar_pend = 0, ar_done = 0, r_pend = 0, rst_done = 0;
    obs_nresp = 0; obs_resp_t = -1; obs_last_t = -1; obs_err = 0; obs_rdata = '0;
    obs_ready_in_done = 1'b0; obs_rst_vec = '1;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = addr; req_wdata = {LW{32'hDEAD_BEEF}};
    axi.ARREADY_M = 1;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      req_valid = 0;
      if (ar_pend) ar_done = 1;
      if (r_pend) begin beat++; gapc = gap; end
      if (resp_valid) note_resp(t);
      if (axi.ARVALID_M) begin
        if (arcnt == 0) begin
          obs_addr = axi.ARADDR_M; obs_len = axi.ARLEN_M; obs_id = axi.ARID_M;
          obs_size = axi.ARSIZE_M; obs_burst = axi.ARBURST_M;
        end
        arcnt++;
      end
      if (rst_beat >= 0 && !rst_done && ar_done && beat == rst_beat) begin
        rst_n = 0; rst_done = 1; rst_t = t;
        #1;
        obs_rst_vec = {axi.ARVALID_M, axi.RREADY_M, axi.AWVALID_M,
                       axi.WVALID_M, axi.BREADY_M, resp_valid};
      end
      if (rst_done && t == rst_t + 2) rst_n = 1;
      if (!rst_done && ar_done && beat <= last_beat && gapc == 0) begin
        axi.RVALID_M = 1; axi.RDATA_M = rwords[beat]; axi.RID_M = 4'd1;
        axi.RLAST_M = (beat == last_beat);
        axi.RRESP_M = (beat == err_beat) ? 2'b10 : 2'b00;
      end else begin
        axi.RVALID_M = 0; axi.RLAST_M = 0;
        if (gapc > 0) gapc--;
      end
      ar_pend = axi.ARVALID_M && axi.ARREADY_M;
      r_pend  = axi.RVALID_M && axi.RREADY_M;
      if (r_pend && axi.RLAST_M) obs_last_t = t;
      if (obs_resp_t >= 0 && t >= obs_resp_t + 3) break;
      if (rst_done && t >= rst_t + 8) break;
    end
    slave_idle();
  endtask

  // Write-back; AWREADY after aw_delay cycles of AWVALID, WREADY optionally toggling.
  task automatic do_wb(input logic [31:0] addr, input logic [32*LW-1:0] data,
                       input int aw_delay, input bit toggle, input logic [1:0] bresp);
    int  awcnt = 0;
    bit  aw_pend = 0, aw_done = 0, b_pend = 0, b_done = 0, stall_prev = 0;
    logic [31:0] prev_wdata = '0;
    obs_nresp = 0; obs_resp_t = -1; obs_last_t = -1; obs_err = 0; obs_rdata = '0;
    obs_nw = 0; obs_w_early = 0; obs_w_unstable = 0; obs_wlast = '0;
    obs_ready_in_done = 1'b0;
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = addr; req_wdata = data;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      req_valid = 0; req_write = 0;
      if (aw_pend) aw_done = 1;
      if (b_pend) b_done = 1;
      if (resp_valid) note_resp(t);
      if (axi.WVALID_M && !aw_done) obs_w_early++;
      if (stall_prev && axi.WDATA_M !== prev_wdata) obs_w_unstable++;
      if (axi.AWVALID_M) begin
        if (awcnt == 0) begin obs_addr = axi.AWADDR_M; obs_len = axi.AWLEN_M; end
        awcnt++;
      end
      axi.AWREADY_M = axi.AWVALID_M && (awcnt > aw_delay);
      if (obs_nw >= LW && !b_done) begin
        axi.BVALID_M = 1; axi.BRESP_M = bresp; axi.BID_M = 4'd1;
      end else axi.BVALID_M = 0;
      b_pend = axi.BVALID_M && axi.BREADY_M;
      if (b_pend) obs_last_t = t;
      axi.WREADY_M = toggle ? (t % 2 == 1) : 1'b1;
      if (axi.WVALID_M && axi.WREADY_M) begin
        if (obs_nw < LW) begin
          obs_wdata[obs_nw] = axi.WDATA_M;
          obs_wlast[obs_nw] = axi.WLAST_M;
        end
        obs_nw++;
      end
      aw_pend = axi.AWVALID_M && axi.AWREADY_M;
      stall_prev = axi.WVALID_M && !axi.WREADY_M;
      prev_wdata = axi.WDATA_M;
      if (obs_resp_t >= 0 && t >= obs_resp_t + 3) break;
    end
    slave_idle();
  endtask

  task automatic push_read(input logic err, input bit known, input logic [32*LW-1:0] line);
    exp_t e;
    e.chk_data = known; e.err = err; e.rdata = line;
    sb.push_back(e);
    held_known = known;
    if (known) held_line = line;
  endtask

  task automatic push_write(input logic err);
    exp_t e;
    e.chk_data = held_known; e.err = err; e.rdata = held_line;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({axi.ARVALID_M, axi.RREADY_M, axi.AWVALID_M, axi.WVALID_M, axi.BREADY_M} !== 5'b0) begin
      errors++; $display("FAIL reset_valids: got %b expected 00000",
        {axi.ARVALID_M, axi.RREADY_M, axi.AWVALID_M, axi.WVALID_M, axi.BREADY_M});
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++;
    if ({resp_valid, resp_err} !== 2'b00) begin
      errors++; $display("FAIL reset_resp: got %b expected 00", {resp_valid, resp_err});
    end
    checks++;
    if (resp_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
  endtask

  task automatic test_refill_basic();
    exp_t e;
    for (int i = 0; i < LW; i++) rwords[i] = 32'hA0 + i;
    push_read(1'b0, 1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    do_refill(32'h2000_0014, 0, -1, LW - 1, -1);
    e = sb.pop_front();
    checks++;
    if (obs_addr !== 32'h2000_0010) begin errors++; $display("FAIL basic_araddr: got %h expected 20000010", obs_addr); end
    checks++;
    if ({obs_len, obs_size, obs_burst, obs_id} !== {4'd3, 3'b010, 2'b01, 4'd1}) begin
      errors++; $display("FAIL basic_arfields: got len %0d size %0d burst %0d id %0d expected 3 2 1 1",
        obs_len, obs_size, obs_burst, obs_id);
    end
    checks++;
    if (obs_resp_t != 6) begin errors++; $display("FAIL basic_latency: got %0d expected 6", obs_resp_t); end
    checks++;
    if (obs_nresp != 1) begin errors++; $display("FAIL basic_nresp: got %0d expected 1", obs_nresp); end
    checks++;
    if (obs_err !== e.err) begin errors++; $display("FAIL basic_err: got %b expected %b", obs_err, e.err); end
    checks++;
    if (obs_rdata !== e.rdata) begin errors++; $display("FAIL basic_rdata: got %h expected %h", obs_rdata, e.rdata); end
    checks++;
    if (obs_ready_in_done !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done: got %b expected 0", obs_ready_in_done); end
  endtask

  task automatic test_refill_stall();
    exp_t e;
    for (int i = 0; i < LW; i++) rwords[i] = 32'hB0 + i;
    push_read(1'b0, 1'b1, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    do_refill(32'h0000_4438, 3, -1, LW - 1, -1);
    e = sb.pop_front();
    checks++;
    if (obs_nresp != 1) begin errors++; $display("FAIL stall_nresp: got %0d expected 1", obs_nresp); end
    checks++;
    if (obs_resp_t != obs_last_t + 1) begin
      errors++; $display("FAIL stall_resp_after_rlast: got %0d expected %0d", obs_resp_t, obs_last_t + 1);
    end
    checks++;
    if (obs_rdata !== e.rdata) begin errors++; $display("FAIL stall_rdata: got %h expected %h", obs_rdata, e.rdata); end
    checks++;
    if (obs_err !== e.err) begin errors++; $display("FAIL stall_err: got %b expected %b", obs_err, e.err); end
  endtask

  task automatic test_rresp_err();
    exp_t e;
    for (int i = 0; i < LW; i++) rwords[i] = 32'hC0 + i;
    push_read(1'b1, 1'b1, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    do_refill(32'h0000_1000, 0, 2, LW - 1, -1);
    e = sb.pop_front();
    checks++;
    if ({obs_nresp == 1, obs_err} !== {1'b1, e.err}) begin
      errors++; $display("FAIL rresp_err: got nresp %0d err %b expected 1 %b", obs_nresp, obs_err, e.err);
    end
    checks++;
    if (obs_rdata !== e.rdata) begin errors++; $display("FAIL rresp_rdata: got %h expected %h", obs_rdata, e.rdata); end
    for (int i = 0; i < LW; i++) rwords[i] = 32'hD0 + i;
    push_read(1'b0, 1'b1, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    do_refill(32'h0000_1010, 1, -1, LW - 1, -1);
    e = sb.pop_front();
    checks++;
    if (obs_err !== e.err) begin errors++; $display("FAIL rresp_clear_err: got %b expected %b", obs_err, e.err); end
    checks++;
    if (obs_rdata !== e.rdata) begin errors++; $display("FAIL rresp_clear_rdata: got %h expected %h", obs_rdata, e.rdata); end
  endtask

  task automatic test_writeback();
    exp_t e;
    logic [31:0] want [LW];
    want[0] = 32'd1; want[1] = 32'd2; want[2] = 32'd3; want[3] = 32'd4;
    push_write(1'b0);
    do_wb(32'h0001_0000, {32'd4, 32'd3, 32'd2, 32'd1}, 5, 1'b1, 2'b00);
    e = sb.pop_front();
    checks++;
    if (obs_addr !== 32'h0001_0000 || obs_len !== 4'd3) begin
      errors++; $display("FAIL wb_aw: got addr %h len %0d expected 00010000 3", obs_addr, obs_len);
    end
    checks++;
    if (obs_w_early != 0) begin errors++; $display("FAIL wb_w_before_aw: got %0d expected 0", obs_w_early); end
    checks++;
    if (obs_nw != LW) begin errors++; $display("FAIL wb_beats: got %0d expected %0d", obs_nw, LW); end
    for (int i = 0; i < LW; i++) begin
      checks++;
      if (obs_wdata[i] !== want[i]) begin
        errors++; $display("FAIL wb_wdata%0d: got %h expected %h", i, obs_wdata[i], want[i]);
      end
    end
    checks++;
    if (obs_wlast !== 4'b1000) begin errors++; $display("FAIL wb_wlast: got %b expected 1000", obs_wlast); end
    checks++;
    if (obs_w_unstable != 0) begin errors++; $display("FAIL wb_wdata_stable: got %0d expected 0", obs_w_unstable); end
    checks++;
    if (axi.WSTRB_M !== 4'hF) begin errors++; $display("FAIL wb_wstrb: got %h expected f", axi.WSTRB_M); end
    checks++;
    if (obs_nresp != 1 || obs_resp_t != obs_last_t + 1) begin
      errors++; $display("FAIL wb_resp: got nresp %0d at %0d expected 1 at %0d", obs_nresp, obs_resp_t, obs_last_t + 1);
    end
    checks++;
    if (obs_err !== e.err) begin errors++; $display("FAIL wb_err: got %b expected %b", obs_err, e.err); end
    if (e.chk_data) begin
      checks++;
      if (obs_rdata !== e.rdata) begin errors++; $display("FAIL wb_rdata_held: got %h expected %h", obs_rdata, e.rdata); end
    end
  endtask

  task automatic test_bresp_err();
    exp_t e;
    push_write(1'b1);
    do_wb(32'h0002_0040, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 1'b0, 2'b11);
    e = sb.pop_front();
    checks++;
    if ({obs_nresp == 1, obs_err} !== {1'b1, e.err}) begin
      errors++; $display("FAIL bresp_err: got nresp %0d err %b expected 1 %b", obs_nresp, obs_err, e.err);
    end
    push_write(1'b0);
    do_wb(32'h0002_0080, {32'h88, 32'h77, 32'h66, 32'h55}, 1, 1'b0, 2'b00);
    e = sb.pop_front();
    checks++;
    if (obs_err !== e.err) begin errors++; $display("FAIL bresp_clear_err: got %b expected %b", obs_err, e.err); end
  endtask

  task automatic test_early_rlast();
    exp_t e;
    for (int i = 0; i < LW; i++) rwords[i] = 32'hE0 + i;
    push_read(1'b1, 1'b0, '0);
    do_refill(32'h0000_2000, 0, -1, 1, -1);
    e = sb.pop_front();
    checks++;
    if ({obs_nresp == 1, obs_err} !== {1'b1, e.err}) begin
      errors++; $display("FAIL early_rlast_err: got nresp %0d err %b expected 1 %b", obs_nresp, obs_err, e.err);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL early_rlast_idle: got %b expected 1", req_ready); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < LW; i++) rwords[i] = 32'hF0 + i;
    do_refill(32'h0000_3000, 0, -1, LW - 1, 2);
    held_line = '0; held_known = 1'b1;
    checks++;
    if (obs_rst_vec !== 6'b0) begin errors++; $display("FAIL rst_mid_valids: got %b expected 000000", obs_rst_vec); end
    checks++;
    if (obs_nresp != 0) begin errors++; $display("FAIL rst_mid_resp: got %0d expected 0", obs_nresp); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    push_write(1'b0);
    do_wb(32'h0003_0000, {32'h1234, 32'h5678, 32'h9ABC, 32'hDEF0}, 0, 1'b0, 2'b00);
    e = sb.pop_front();
    checks++;
    if (obs_rdata !== e.rdata) begin errors++; $display("FAIL b2b_wb_rdata: got %h expected %h", obs_rdata, e.rdata); end
    for (int i = 0; i < LW; i++) rwords[i] = 32'h5000 + i;
    push_read(1'b0, 1'b1, {32'h5003, 32'h5002, 32'h5001, 32'h5000});
    do_refill(32'h0003_001C, 0, -1, LW - 1, -1);
    e = sb.pop_front();
    checks++;
    if (obs_rdata !== e.rdata || obs_err !== e.err) begin
      errors++; $display("FAIL b2b_refill: got %h err %b expected %h err %b", obs_rdata, obs_err, e.rdata, e.err);
    end
    checks++;
    if (obs_addr !== 32'h0003_0010) begin errors++; $display("FAIL b2b_araddr: got %h expected 00030010", obs_addr); end
    checks++;
    if (obs_ready_in_done !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done: got %b expected 0", obs_ready_in_done); end
  endtask

  initial begin
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    slave_idle();
    test_reset();
    test_refill_basic();
    test_refill_stall();
    test_rresp_err();
    test_writeback();
    test_bresp_err();
    test_early_rlast();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end
endmodule
`default_nettype wire
